// File: rtl/alu_control_pipe.sv
// Registered ALU-control stage with a one-entry skid buffer and valid/ready on both sides.
// Optional saturating illegal-op counter is compiled in with `define ALU_CTRL_ILLEGAL_CNT_EN.
module alu_control_pipe #(
    parameter int OPW  = 11
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
    ,
    parameter int CNTW = 16
`endif
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [1:0]     in_aluop,
    input  logic [OPW-1:0] in_opcode,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [3:0]     out_alu_opcode,
    output logic           out_illegal
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
    ,
    output logic [CNTW-1:0] illegal_count
`endif
);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_ONE,
        S_FULL
    } state_t;

    state_t     state_q;
    logic       in_ready_q;
    logic       out_valid_q;
    logic [3:0] out_op_q;
    logic       out_ill_q;
    logic [3:0] skid_op_q;
    logic       skid_ill_q;

    logic [3:0] dec_op_d;
    logic       dec_ill_d;
    logic       accept;
    logic       consume;

    assign accept  = in_valid & in_ready_q;
    assign consume = out_valid_q & out_ready;

    always_comb begin
        dec_op_d  = 4'b0010;
        dec_ill_d = 1'b0;
        case (in_aluop)
            2'b00: dec_op_d = 4'b0010;
            2'b01: dec_op_d = 4'b0111;
            2'b10: begin
                case (in_opcode)
                    11'b10001011000: dec_op_d = 4'b0010;
                    11'b11001011000: dec_op_d = 4'b0110;
                    11'b10001010000: dec_op_d = 4'b0000;
                    11'b10101010000: dec_op_d = 4'b0001;
                    default:         dec_ill_d = 1'b1;
                endcase
            end
            default: dec_ill_d = 1'b1;
        endcase
    end

    // in_ready is low exactly while SKID holds an entry, so FULL never sees an accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_op_q    <= '0;
            out_ill_q   <= 1'b0;
            skid_op_q   <= '0;
            skid_ill_q  <= 1'b0;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        out_op_q    <= dec_op_d;
                        out_ill_q   <= dec_ill_d;
                        out_valid_q <= 1'b1;
                        state_q     <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (accept && consume) begin
                        out_op_q  <= dec_op_d;
                        out_ill_q <= dec_ill_d;
                    end else if (accept) begin
                        skid_op_q  <= dec_op_d;
                        skid_ill_q <= dec_ill_d;
                        in_ready_q <= 1'b0;
                        state_q    <= S_FULL;
                    end else if (consume) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (consume) begin
                        out_op_q   <= skid_op_q;
                        out_ill_q  <= skid_ill_q;
                        in_ready_q <= 1'b1;
                        state_q    <= S_ONE;
                    end
                end
                default: begin
                    state_q     <= S_EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = out_valid_q;
    assign out_alu_opcode = out_op_q;
    assign out_illegal    = out_ill_q;

`ifdef ALU_CTRL_ILLEGAL_CNT_EN
    logic [CNTW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (accept && dec_ill_d && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign illegal_count = cnt_q;
`endif

endmodule

// File: tb/tb_alu_control_pipe.sv
// Directed self-checking bench for alu_control_pipe; counter checks are built when
// ALU_CTRL_ILLEGAL_CNT_EN is defined.
module tb_alu_control_pipe;

    localparam logic [10:0] OP_ADD = 11'b10001011000;
    localparam logic [10:0] OP_SUB = 11'b11001011000;
    localparam logic [10:0] OP_AND = 11'b10001010000;
    localparam logic [10:0] OP_ORR = 11'b10101010000;
    localparam logic [10:0] OP_BAD = 11'b11111000010;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_aluop;
    logic [10:0] in_opcode;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_alu_opcode;
    logic        out_illegal;

    int n_assert;
    int n_fail;

`ifdef ALU_CTRL_ILLEGAL_CNT_EN
    logic [15:0] illegal_count;
    logic        in_ready2;
    logic        out_valid2;
    logic [3:0]  out_alu_opcode2;
    logic        out_illegal2;
    logic [1:0]  illegal_count2;

    alu_control_pipe #(.OPW(11), .CNTW(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_aluop(in_aluop), .in_opcode(in_opcode), .out_valid(out_valid),
        .out_ready(out_ready), .out_alu_opcode(out_alu_opcode),
        .out_illegal(out_illegal), .illegal_count(illegal_count)
    );

    alu_control_pipe #(.OPW(11), .CNTW(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_aluop(in_aluop), .in_opcode(in_opcode), .out_valid(out_valid2),
        .out_ready(out_ready), .out_alu_opcode(out_alu_opcode2),
        .out_illegal(out_illegal2), .illegal_count(illegal_count2)
    );
`else
    alu_control_pipe #(.OPW(11)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_aluop(in_aluop), .in_opcode(in_opcode), .out_valid(out_valid),
        .out_ready(out_ready), .out_alu_opcode(out_alu_opcode),
        .out_illegal(out_illegal)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] aop, input logic [10:0] opc);
        in_valid  = v;
        in_aluop  = aop;
        in_opcode = opc;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [3:0] op,
                             input logic ill, input logic rdy);
        check({tag, ".valid"}, {15'd0, out_valid}, {15'd0, v});
        check({tag, ".op"}, {12'd0, out_alu_opcode}, {12'd0, op});
        check({tag, ".illegal"}, {15'd0, out_illegal}, {15'd0, ill});
        check({tag, ".in_ready"}, {15'd0, in_ready}, {15'd0, rdy});
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 2'b00, 11'd0);
        #2;
        check_out("reset", 1'b0, 4'b0000, 1'b0, 1'b1);
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
        check("reset.count", illegal_count, 16'd0);
`endif
        #10 rst = 1'b0;
        step();

        // Decode sweep, consumed every cycle
        out_ready = 1'b1;
        drive(1'b1, 2'b00, OP_BAD); step(); check_out("dec00", 1'b1, 4'b0010, 1'b0, 1'b1);
        drive(1'b1, 2'b01, OP_SUB); step(); check_out("dec01", 1'b1, 4'b0111, 1'b0, 1'b1);
        drive(1'b1, 2'b10, OP_ADD); step(); check_out("decADD", 1'b1, 4'b0010, 1'b0, 1'b1);
        drive(1'b1, 2'b10, OP_SUB); step(); check_out("decSUB", 1'b1, 4'b0110, 1'b0, 1'b1);
        drive(1'b1, 2'b10, OP_AND); step(); check_out("decAND", 1'b1, 4'b0000, 1'b0, 1'b1);
        drive(1'b1, 2'b10, OP_ORR); step(); check_out("decORR", 1'b1, 4'b0001, 1'b0, 1'b1);
        drive(1'b1, 2'b10, OP_BAD); step(); check_out("decBAD", 1'b1, 4'b0010, 1'b1, 1'b1);
        drive(1'b1, 2'b11, OP_ADD); step(); check_out("dec11", 1'b1, 4'b0010, 1'b1, 1'b1);

        // Idle with unknown data must not load anything
        drive(1'b0, 2'bxx, 11'bx); step();
        check("idle.valid", {15'd0, out_valid}, 16'd0);
        check("idle.in_ready", {15'd0, in_ready}, 16'd1);
        step();
        check("idle2.valid", {15'd0, out_valid}, 16'd0);

        // Backpressure: SUB to OUT, AND to SKID, ORR refused
        out_ready = 1'b0;
        drive(1'b1, 2'b10, OP_SUB); step(); check_out("bp.sub", 1'b1, 4'b0110, 1'b0, 1'b1);
        drive(1'b1, 2'b10, OP_AND); step(); check_out("bp.full", 1'b1, 4'b0110, 1'b0, 1'b0);
        drive(1'b1, 2'b10, OP_ORR); step(); check_out("bp.hold", 1'b1, 4'b0110, 1'b0, 1'b0);
        out_ready = 1'b1;
        step(); check_out("bp.and", 1'b1, 4'b0000, 1'b0, 1'b1);
        step(); check_out("bp.orr", 1'b1, 4'b0001, 1'b0, 1'b1);
        drive(1'b0, 2'b00, 11'd0);
        step(); check("bp.drain", {15'd0, out_valid}, 16'd0);

        // Sustained accept+consume
        for (int i = 0; i < 8; i++) begin
            case (i % 4)
                0: drive(1'b1, 2'b10, OP_ADD);
                1: drive(1'b1, 2'b10, OP_SUB);
                2: drive(1'b1, 2'b10, OP_AND);
                default: drive(1'b1, 2'b10, OP_ORR);
            endcase
            step();
            case (i % 4)
                0: check_out("tput", 1'b1, 4'b0010, 1'b0, 1'b1);
                1: check_out("tput", 1'b1, 4'b0110, 1'b0, 1'b1);
                2: check_out("tput", 1'b1, 4'b0000, 1'b0, 1'b1);
                default: check_out("tput", 1'b1, 4'b0001, 1'b0, 1'b1);
            endcase
        end
        drive(1'b0, 2'b00, 11'd0);
        step();

        // Reset mid-stream from FULL
        out_ready = 1'b0;
        drive(1'b1, 2'b11, OP_ADD); step();
        drive(1'b1, 2'b10, OP_SUB); step();
        check_out("pre_rst", 1'b1, 4'b0010, 1'b1, 1'b0);
        drive(1'b0, 2'b00, 11'd0);
        #1 rst = 1'b1;
        #1 check_out("async_rst", 1'b0, 4'b0000, 1'b0, 1'b1);
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
        check("rst.count", illegal_count, 16'd0);
`endif
        #1 rst = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 2'b10, OP_ADD); step();
        check_out("post_rst", 1'b1, 4'b0010, 1'b0, 1'b1);

`ifdef ALU_CTRL_ILLEGAL_CNT_EN
        drive(1'b1, 2'b11, OP_ADD); step();
        drive(1'b1, 2'b10, OP_AND); step();
        drive(1'b1, 2'b10, OP_BAD); step();
        drive(1'b1, 2'b00, OP_BAD); step();
        drive(1'b1, 2'b11, OP_SUB); step();
        check("cnt3", illegal_count, 16'd3);
        check("cnt3.w2", {14'd0, illegal_count2}, 16'd3);
        drive(1'b1, 2'b11, OP_ADD); step();
        drive(1'b1, 2'b10, OP_BAD); step();
        check("cnt5", illegal_count, 16'd5);
        check("sat.w2", {14'd0, illegal_count2}, 16'd3);
        drive(1'b0, 2'b00, 11'd0); step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_control_pipe.md
# alu_control_pipe

Registered ALU-control stage between instruction decode and the 64-bit ALU. Takes the 2-bit ALUOp class from main control plus the 11-bit instruction opcode field and produces the 4-bit ALU operation code and an illegal-operation flag. Uses a valid/ready handshake on both sides. A one-entry skid buffer gives full throughput and a registered `in_ready`, so a stall from the execute stage never combinationally reaches decode.

## Interface
Parameters:
- `OPW`, 11, width of the instruction opcode field.
- `CNTW`, 16, width of the illegal-op counter (only when the counter feature is compiled in).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `in_valid`  in  1  decode presents an operation.
- `in_ready`  out  1  stage can accept; registered, equals "skid buffer empty".
- `in_aluop`  in  2  ALUOp class from main control.
- `in_opcode`  in  OPW  instruction bits [31:21].
- `out_valid`  out  1  output register holds an operation.
- `out_ready`  in  1  execute stage consumes the operation.
- `out_alu_opcode`  out  4  ALU operation code.
- `out_illegal`  out  1  the operation decoded as illegal.
- `illegal_count`  out  CNTW  saturating count of illegal ops accepted (only with `ALU_CTRL_ILLEGAL_CNT_EN`).

## Operation
- Decode is combinational on the input side and is stored as {alu_opcode, illegal}:
  - ALUOp 00: 0010 (add; load/store address).
  - ALUOp 01: 0111 (pass operand 2; CBZ).
  - ALUOp 10, opcode 10001011000: 0010 (ADD).
  - ALUOp 10, opcode 11001011000: 0110 (SUB).
  - ALUOp 10, opcode 10001010000: 0000 (AND).
  - ALUOp 10, opcode 10101010000: 0001 (ORR).
  - ALUOp 10 with any other opcode, or ALUOp 11: alu_opcode 0010, illegal=1.
- Storage is an output register (OUT) and a skid register (SKID), each with its own valid bit.
- Accept = `in_valid & in_ready`. Consume = `out_valid & out_ready`.
- Each cycle applies the first matching rule:
  - Consume with SKID full: SKID moves to OUT, SKID empties. `in_ready` is low, so nothing is accepted.
  - Accept while OUT is empty or being consumed: the decoded op loads OUT.
  - Accept while OUT is full and not consumed: the decoded op loads SKID.
  - Consume with no accept: OUT empties.
- States are EMPTY (OUT invalid), ONE (OUT valid, SKID empty) and FULL (both valid). Transitions:
  - EMPTY to ONE on accept.
  - ONE stays ONE on accept with consume, goes to FULL on accept without consume, goes to EMPTY on consume without accept.
  - FULL goes to ONE on consume; otherwise it holds.
- Ordering is strictly FIFO. No operation is dropped or duplicated.
- OUT contents are stable while `out_valid & ~out_ready`.

## Timing
- Reset values:
  - `out_valid`=0, `out_alu_opcode`=0000, `out_illegal`=0.
  - `in_ready`=1, SKID empty.
  - `illegal_count`=0.
- Reset asserted mid-operation discards OUT and SKID immediately (asynchronously). The first accept is possible in the first cycle after deassertion.
- Latency: an op accepted at edge N is visible on the outputs after edge N with `out_valid`=1, i.e. one cycle.
- Throughput is one op per cycle while `out_ready` stays high.
- `in_ready` falls in the cycle after SKID fills. It rises in the cycle after SKID drains.
- `in_opcode` is ignored unless ALUOp is 10.
- X on data inputs while `in_valid`=0 has no effect on state.

## Configuration
- `ALU_CTRL_ILLEGAL_CNT_EN` defined:
  - `illegal_count` port exists.
  - The counter increments on every accepted op that decodes as illegal.
  - It saturates at all-ones and is cleared only by `rst`.
- Not defined:
  - The port and the counter logic are absent.
  - All other behaviour is identical.

## Test plan
- Reset mid-stream: assert `rst` with FULL state -> `out_valid`=0, `in_ready`=1 immediately; the next accepted ADD appears as 0010 one cycle later.
- Full decode sweep with `out_ready`=1:
  - ALUOp 00 -> 0010.
  - ALUOp 01 -> 0111.
  - ALUOp 10 with ADD/SUB/AND/ORR opcodes -> 0010/0110/0000/0001.
  - ALUOp 10 with opcode 11111000010 -> illegal=1, 0010.
  - ALUOp 11 -> illegal=1.
  - Each result appears one cycle after its accept.
- Backpressure: streaming SUB, AND, ORR with `out_ready`=0 from the second cycle:
  - SUB is held in OUT and AND in SKID.
  - `in_ready`=0 the cycle after AND is accepted; ORR is not accepted.
  - After `out_ready`=1, the outputs are SUB, AND, ORR in order with no gaps beyond one cycle.
- Simultaneous accept and consume in ONE for 8 cycles -> `in_ready` stays 1 and an op is delivered every cycle.
- With the macro defined:
  - 3 illegal ops interleaved with 2 legal ops -> `illegal_count`=3.
  - With `CNTW`=2, 5 illegal ops -> `illegal_count` saturates at 3.
